// File: rtl/or1200_checker_pkg.sv
// rtl/or1200_checker_pkg.sv - shared state encoding, fault-code bit indices and supervisor parity decode
package or1200_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FREEZE = 3'd1,
    ST_RESET  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_LOCK   = 3'd4
  } resp_state_t;

  localparam int FC_SR   = 0;
  localparam int FC_PIPE = 1;
  localparam int FC_MMU  = 2;
  localparam int FC_SUPV = 3;

  // Even parity on the checker word means the checker asserts supervisor mode.
  function automatic logic supv_decode(input logic [2:0] word);
    return ~^word;
  endfunction

endpackage

// File: rtl/or1200_checker_filter.sv
// rtl/or1200_checker_filter.sv - registers checker verdicts and confirms a run of FILTER_LEN bad samples
module or1200_checker_filter #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sr_ok,
  input  logic       pipeline_ok,
  input  logic       mmus_ok,
  input  logic [2:0] secure_supv,
  input  logic       sr_sm,
  input  logic       idle,
  input  logic       clear,
  output logic       confirm,
  output logic [3:0] code
);
  import or1200_checker_pkg::*;

  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] bad;
  logic [3:0] bad_q;
  logic [3:0] bad_acc;
  logic [3:0] filt_cnt;

  always_comb begin
    bad          = '0;
    bad[FC_SR]   = ~sr_ok;
    bad[FC_PIPE] = ~pipeline_ok;
    bad[FC_MMU]  = ~mmus_ok;
    bad[FC_SUPV] = supv_decode(secure_supv) != sr_sm;
  end

  // Outside IDLE the run is frozen: post-reset checker glitches must not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad_q    <= '0;
      bad_acc  <= '0;
      filt_cnt <= '0;
    end else begin
      bad_q <= bad;
      if (clear || bad_q == 4'd0) begin
        bad_acc  <= '0;
        filt_cnt <= '0;
      end else if (idle) begin
        bad_acc  <= bad_acc | bad_q;
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign confirm = idle && (|bad_q) && (filt_cnt == FILT_LAST);
  assign code    = bad_acc | bad_q;

endmodule

// File: rtl/or1200_checker_response.sv
// rtl/or1200_checker_response.sv - fault escalation FSM and record publisher; optional lockout via OR1200_CHECKER_RESP_LOCKOUT_EN
module or1200_checker_response #(
  parameter int unsigned FILTER_LEN    = 2,
  parameter int unsigned FREEZE_CYCLES = 8,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned MAX_FAULTS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sr_ok,
  input  logic       pipeline_ok,
  input  logic       mmus_ok,
  input  logic [2:0] secure_supv,
  input  logic       sr_sm,
  output logic       freeze_req,
  output logic       rst_req,
  output logic       locked,
  output logic       fault_valid,
  input  logic       fault_ready,
  output logic [3:0] fault_code,
  output logic [3:0] fault_count
);
  import or1200_checker_pkg::*;

`ifdef OR1200_CHECKER_RESP_LOCKOUT_EN
  localparam logic LOCKOUT_ON = 1'b1;
`else
  localparam logic LOCKOUT_ON = 1'b0;
`endif

  localparam logic [7:0] FREEZE_LAST = 8'(FREEZE_CYCLES - 1);
  localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [3:0] MAX_F       = 4'(MAX_FAULTS);

  resp_state_t state;
  logic [7:0]  timer;
  logic        locked_q;
  logic        confirm;
  logic [3:0]  acc_code;
  logic [3:0]  count_next;
  logic        lock_hit;

  or1200_checker_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk         (clk),
    .rst         (rst),
    .sr_ok       (sr_ok),
    .pipeline_ok (pipeline_ok),
    .mmus_ok     (mmus_ok),
    .secure_supv (secure_supv),
    .sr_sm       (sr_sm),
    .idle        (state == ST_IDLE),
    .clear       (state == ST_DRAIN && !fault_valid),
    .confirm     (confirm),
    .code        (acc_code)
  );

  assign count_next = (fault_count == 4'hf) ? fault_count : fault_count + 4'd1;
  assign lock_hit   = LOCKOUT_ON && (count_next == MAX_F);
  assign locked     = locked_q & LOCKOUT_ON;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      freeze_req  <= 1'b0;
      rst_req     <= 1'b0;
      locked_q    <= 1'b0;
      fault_valid <= 1'b0;
      fault_code  <= '0;
      fault_count <= '0;
    end else begin
      if (fault_valid && fault_ready)
        fault_valid <= 1'b0;
      case (state)
        ST_IDLE: if (confirm) begin
          fault_code  <= acc_code;
          fault_valid <= 1'b1;
          fault_count <= count_next;
          freeze_req  <= 1'b1;
          timer       <= '0;
          if (lock_hit) begin
            locked_q <= 1'b1;
            state    <= ST_LOCK;
          end else begin
            state <= ST_FREEZE;
          end
        end
        ST_FREEZE: if (timer == FREEZE_LAST) begin
          timer   <= '0;
          rst_req <= 1'b1;
          state   <= ST_RESET;
        end else begin
          timer <= timer + 8'd1;
        end
        ST_RESET: if (timer == RST_LAST) begin
          timer   <= '0;
          rst_req <= 1'b0;
          state   <= ST_DRAIN;
        end else begin
          timer <= timer + 8'd1;
        end
        // Only one outstanding record: stay frozen until the logger takes it.
        ST_DRAIN: if (!fault_valid) begin
          freeze_req <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_LOCK: freeze_req <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or1200_checker_response.sv
// tb/tb_or1200_checker_response.sv - self-checking bench for the checker response block
module tb_or1200_checker_response;
  localparam int FILTER_LEN    = 2;
  localparam int FREEZE_CYCLES = 8;
  localparam int RST_CYCLES    = 4;
  localparam int MAX_FAULTS    = 3;
  localparam int T_F = FILTER_LEN + 1;
  localparam int T_R = T_F + FREEZE_CYCLES;
  localparam int T_D = T_R + RST_CYCLES;

  logic       clk = 1'b0;
  logic       rst, sr_ok, pipeline_ok, mmus_ok, sr_sm, fault_ready;
  logic [2:0] secure_supv;
  logic       freeze_req, rst_req, locked, fault_valid;
  logic [3:0] fault_code, fault_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  or1200_checker_response #(
    .FILTER_LEN(FILTER_LEN), .FREEZE_CYCLES(FREEZE_CYCLES),
    .RST_CYCLES(RST_CYCLES), .MAX_FAULTS(MAX_FAULTS)
  ) dut (
    .clk(clk), .rst(rst), .sr_ok(sr_ok), .pipeline_ok(pipeline_ok), .mmus_ok(mmus_ok),
    .secure_supv(secure_supv), .sr_sm(sr_sm), .freeze_req(freeze_req), .rst_req(rst_req),
    .locked(locked), .fault_valid(fault_valid), .fault_ready(fault_ready),
    .fault_code(fault_code), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bad(input logic [3:0] b);
    logic [2:0] w;
    logic       sm;
    sr_ok       = ~b[0];
    pipeline_ok = ~b[1];
    mmus_ok     = ~b[2];
    sm          = 1'($urandom_range(0, 1));
    do w = 3'($urandom_range(0, 7)); while ((((~^w) != sm) ? 1'b1 : 1'b0) != b[3]);
    sr_sm       = sm;
    secure_supv = w;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; fault_ready = 1'b0; drive_bad(4'd0);
    tick(); tick();
    rst = 1'b0;
    exp_count = 0;
    checks++;
    if ({freeze_req, rst_req, locked, fault_valid, fault_code, fault_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state got=%h want=000",
               {freeze_req, rst_req, locked, fault_valid, fault_code, fault_count});
    end
  endtask

  task automatic test_glitch();
    drive_bad(4'b0100); tick(); drive_bad(4'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({freeze_req, fault_valid} !== 2'b00) begin
        errors++; $display("FAIL glitch_no_freeze cyc=%0d got=%b want=00", c, {freeze_req, fault_valid});
      end
    end
    checks++;
    if (fault_count !== 4'(exp_count)) begin
      errors++; $display("FAIL glitch_count got=%0d want=%0d", fault_count, exp_count);
    end
  endtask

  task automatic test_sr_fault_and_stall();
    fault_ready = 1'b0;
    drive_bad(4'b0001); tick(); tick(); drive_bad(4'd0);
    checks++;
    if (freeze_req !== 1'b0) begin errors++; $display("FAIL sr_early_freeze got=%b want=0", freeze_req); end
    tick();
    exp_count = sat_inc(exp_count);
    checks++;
    if ({freeze_req, fault_valid, rst_req, fault_code, fault_count} !== {3'b110, 4'b0001, 4'(exp_count)}) begin
      errors++; $display("FAIL sr_confirm got=%b_%b_%0d want=110_0001_%0d",
                         {freeze_req, fault_valid, rst_req}, fault_code, fault_count, exp_count);
    end
    for (int c = T_F + 1; c <= T_D; c++) begin
      tick();
      checks++;
      if ({freeze_req, rst_req} !== {1'b1, (c >= T_R && c < T_D)}) begin
        errors++; $display("FAIL sr_rst_window cyc=N+%0d got=%b want=%b", c, {freeze_req, rst_req},
                           {1'b1, (c >= T_R && c < T_D)});
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({freeze_req, fault_valid, fault_code} !== {2'b11, 4'b0001}) begin
        errors++; $display("FAIL drain_stall cyc=%0d got=%b want=110001", c, {freeze_req, fault_valid, fault_code});
      end
    end
    fault_ready = 1'b1; tick(); fault_ready = 1'b0;
    checks++;
    if ({freeze_req, fault_valid} !== 2'b10) begin
      errors++; $display("FAIL drain_consume got=%b want=10", {freeze_req, fault_valid});
    end
    tick();
    checks++;
    if (freeze_req !== 1'b0) begin errors++; $display("FAIL drain_exit got=%b want=0", freeze_req); end
  endtask

  task automatic test_supv_pipe_back_to_back();
    fault_ready = 1'b1;
    sr_ok = 1'b1; mmus_ok = 1'b1; pipeline_ok = 1'b1; secure_supv = 3'b011; sr_sm = 1'b0;
    tick();
    pipeline_ok = 1'b0;
    tick();
    drive_bad(4'd0);
    tick();
    exp_count = sat_inc(exp_count);
    checks++;
    if ({freeze_req, fault_valid, fault_code, fault_count} !== {2'b11, 4'b1010, 4'(exp_count)}) begin
      errors++; $display("FAIL supv_pipe_code got=%b_%b_%0d want=11_1010_%0d",
                         {freeze_req, fault_valid}, fault_code, fault_count, exp_count);
    end
    tick();
    checks++;
    if ({freeze_req, fault_valid} !== 2'b10) begin
      errors++; $display("FAIL ready_early_consume got=%b want=10", {freeze_req, fault_valid});
    end
    for (int c = T_F + 2; c <= T_D + 1; c++) tick();
    checks++;
    if (freeze_req !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", freeze_req); end
    fault_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    exp_count = 0;
    drive_bad(4'b0100); tick(); tick(); drive_bad(4'd0);
    for (int c = 2; c < T_R + 1; c++) tick();
    checks++;
    if ({freeze_req, rst_req} !== 2'b11) begin
      errors++; $display("FAIL mid_reset_pre got=%b want=11", {freeze_req, rst_req});
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({freeze_req, rst_req, locked, fault_valid, fault_code, fault_count} !== 12'h000) begin
      errors++; $display("FAIL mid_reset_clear got=%h want=000",
                         {freeze_req, rst_req, locked, fault_valid, fault_code, fault_count});
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] v[3];
    logic [3:0] exp_code;
    logic       r, fault, ef, er, ev;
    int         k;
    for (int e = 0; e < 24; e++) begin
      k = $urandom_range(1, 3);
      for (int i = 0; i < 3; i++) v[i] = 4'($urandom_range(1, 15));
      fault = (k >= FILTER_LEN);
      exp_code = 4'd0;
      for (int i = 0; i < FILTER_LEN; i++) exp_code |= v[i];
      if (fault) exp_count = sat_inc(exp_count);
      r = 1'($urandom_range(0, 1));
      fault_ready = r;
      for (int c = 0; c <= T_D + 1; c++) begin
        ef = fault && c >= T_F && (c <= T_D || !r);
        er = fault && c >= T_R && c < T_D;
        ev = fault && c >= T_F && (c == T_F || !r);
        checks++;
        if ({freeze_req, rst_req, fault_valid} !== {ef, er, ev}) begin
          errors++; $display("FAIL rand_ctrl ep=%0d cyc=%0d got=%b want=%b", e, c,
                             {freeze_req, rst_req, fault_valid}, {ef, er, ev});
        end
        if (fault && c == T_F) begin
          checks++;
          if ({fault_code, fault_count} !== {exp_code, 4'(exp_count)}) begin
            errors++; $display("FAIL rand_record ep=%0d got=%b_%0d want=%b_%0d", e,
                               fault_code, fault_count, exp_code, exp_count);
          end
        end
        if (c <= T_D) begin
          drive_bad((c < k) ? v[c] : 4'd0);
          tick();
        end
      end
      if (fault && !r) begin
        fault_ready = 1'b0;
        for (int d = $urandom_range(0, 4); d > 0; d--) tick();
        fault_ready = 1'b1; tick(); fault_ready = 1'b0;
        checks++;
        if ({freeze_req, fault_valid} !== 2'b10) begin
          errors++; $display("FAIL rand_consume ep=%0d got=%b want=10", e, {freeze_req, fault_valid});
        end
        tick();
        checks++;
        if (freeze_req !== 1'b0) begin errors++; $display("FAIL rand_idle ep=%0d got=%b want=0", e, freeze_req); end
      end
      fault_ready = 1'b0;
      tick();
      checks++;
      if (fault_count !== 4'(exp_count)) begin
        errors++; $display("FAIL rand_count ep=%0d got=%0d want=%0d", e, fault_count, exp_count);
      end
    end
  endtask

  task automatic test_lockout();
    rst = 1'b1; tick(); rst = 1'b0;
    fault_ready = 1'b1;
    for (int f = 1; f <= MAX_FAULTS; f++) begin
      drive_bad(4'($urandom_range(1, 15))); tick(); tick(); drive_bad(4'd0); tick();
      checks++;
      if ({freeze_req, locked, fault_count} !== {1'b1, (f == MAX_FAULTS), 4'(f)}) begin
        errors++; $display("FAIL lock_confirm f=%0d got=%b_%0d want=1%b_%0d", f,
                           {freeze_req, locked}, fault_count, (f == MAX_FAULTS), f);
      end
      if (f < MAX_FAULTS) begin
        for (int c = T_F; c <= T_D; c++) tick();
        checks++;
        if (freeze_req !== 1'b0) begin errors++; $display("FAIL lock_pre_idle f=%0d got=%b want=0", f, freeze_req); end
      end
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({freeze_req, rst_req, locked, fault_valid} !== 4'b1010) begin
        errors++; $display("FAIL lock_hold cyc=%0d got=%b want=1010", c, {freeze_req, rst_req, locked, fault_valid});
      end
    end
    fault_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({freeze_req, rst_req, locked, fault_valid, fault_code, fault_count} !== 12'h000) begin
      errors++; $display("FAIL lock_reset got=%h want=000",
                         {freeze_req, rst_req, locked, fault_valid, fault_code, fault_count});
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_sr_fault_and_stall();
    test_supv_pipe_back_to_back();
    test_reset_mid();
`ifdef OR1200_CHECKER_RESP_LOCKOUT_EN
    test_lockout();
`else
    test_random();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL locked_tied got=%b want=0", locked); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
